// File: rtl/id_ex_queue.sv
// id_ex_queue: decode-to-execute circular queue with writeback operand patching
module id_ex_queue #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 2,
  parameter int CTRL_W    = 24,
  parameter int BYPASS_EN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [XLEN-1:0]              in_pcp4,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [XLEN-1:0]              in_imm,
  input  logic [4:0]                   in_rs1,
  input  logic [4:0]                   in_rs2,
  input  logic [4:0]                   in_rd,
  input  logic [XLEN-1:0]              in_rs1_data,
  input  logic [XLEN-1:0]              in_rs2_data,
  input  logic                         wb_en,
  input  logic [4:0]                   wb_rd,
  input  logic [XLEN-1:0]              wb_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_pcp4,
  output logic [XLEN-1:0]              out_imm,
  output logic [XLEN-1:0]              out_rs1_data,
  output logic [XLEN-1:0]              out_rs2_data,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [4:0]                   out_rd,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;
  logic [DEPTH-1:0]  vld_q;
  logic [XLEN-1:0]   pc_q [DEPTH];
  logic [XLEN-1:0]   pcp4_q [DEPTH];
  logic [XLEN-1:0]   imm_q [DEPTH];
  logic [XLEN-1:0]   rs1d_q [DEPTH];
  logic [XLEN-1:0]   rs2d_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [4:0]        rs1_q [DEPTH];
  logic [4:0]        rs2_q [DEPTH];
  logic [4:0]        rd_q [DEPTH];
  logic              enq, deq, wb_hit;
  logic [XLEN-1:0]   rs1_fwd, rs2_fwd;
  always_comb begin
    in_ready  = (count_q < CW'(DEPTH)) && !flush;
    out_valid = count_q != '0;
    enq       = in_valid && in_ready;
    deq       = out_valid && out_ready;
    wb_hit    = (BYPASS_EN != 0) && wb_en && (wb_rd != 5'd0);
    rs1_fwd   = (wb_hit && wb_rd == in_rs1) ? wb_data : in_rs1_data;
    rs2_fwd   = (wb_hit && wb_rd == in_rs2) ? wb_data : in_rs2_data;
    count        = count_q;
    out_pc       = out_valid ? pc_q[head_q]   : '0;
    out_pcp4     = out_valid ? pcp4_q[head_q] : '0;
    out_imm      = out_valid ? imm_q[head_q]  : '0;
    out_rs1_data = out_valid ? rs1d_q[head_q] : '0;
    out_rs2_data = out_valid ? rs2d_q[head_q] : '0;
    out_ctrl     = out_valid ? ctrl_q[head_q] : '0;
    out_rs1      = out_valid ? rs1_q[head_q]  : '0;
    out_rs2      = out_valid ? rs2_q[head_q]  : '0;
    out_rd       = out_valid ? rd_q[head_q]   : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        pcp4_q[i] <= '0;
        imm_q[i]  <= '0;
        rs1d_q[i] <= '0;
        rs2d_q[i] <= '0;
        ctrl_q[i] <= '0;
        rs1_q[i]  <= '0;
        rs2_q[i]  <= '0;
        rd_q[i]   <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && wb_hit && wb_rd == rs1_q[i]) rs1d_q[i] <= wb_data;
        if (vld_q[i] && wb_hit && wb_rd == rs2_q[i]) rs2d_q[i] <= wb_data;
      end
      // the tail slot is never valid while enqueueing, so this cannot clash with patching
      if (enq) begin
        pc_q[tail_q]   <= in_pc;
        pcp4_q[tail_q] <= in_pcp4;
        imm_q[tail_q]  <= in_imm;
        rs1d_q[tail_q] <= rs1_fwd;
        rs2d_q[tail_q] <= rs2_fwd;
        ctrl_q[tail_q] <= in_ctrl;
        rs1_q[tail_q]  <= in_rs1;
        rs2_q[tail_q]  <= in_rs2;
        rd_q[tail_q]   <= in_rd;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + 1'b1;
      end
      if (deq) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(enq) - CW'(deq);
    end
  end
endmodule

// File: tb/tb_id_ex_queue.sv
// tb_id_ex_queue: directed scenario checks for id_ex_queue with and without bypass
module tb_id_ex_queue;
  logic clk = 0, rst = 1, in_valid = 0, wb_en = 0, flush = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_pcp4 = 0, in_imm = 0, in_rs1_data = 0, in_rs2_data = 0, wb_data = 0;
  logic [23:0] in_ctrl = 0;
  logic [4:0]  in_rs1 = 0, in_rs2 = 0, in_rd = 0, wb_rd = 0;
  logic        in_ready, out_valid, in_ready_b, out_valid_b;
  logic [31:0] out_pc, out_pcp4, out_imm, out_rs1_data, out_rs2_data;
  logic [31:0] out_pc_b, out_pcp4_b, out_imm_b, out_rs1_data_b, out_rs2_data_b;
  logic [23:0] out_ctrl, out_ctrl_b;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_rs1_b, out_rs2_b, out_rd_b;
  logic [1:0]  count, count_b;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  id_ex_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_pcp4(in_pcp4),
    .in_ctrl(in_ctrl), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pcp4(out_pcp4),
    .out_imm(out_imm), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_ctrl(out_ctrl),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .count(count));

  id_ex_queue #(.BYPASS_EN(0)) dut_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_pc(in_pc), .in_pcp4(in_pcp4),
    .in_ctrl(in_ctrl), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b), .out_pcp4(out_pcp4_b),
    .out_imm(out_imm_b), .out_rs1_data(out_rs1_data_b), .out_rs2_data(out_rs2_data_b), .out_ctrl(out_ctrl_b),
    .out_rs1(out_rs1_b), .out_rs2(out_rs2_b), .out_rd(out_rd_b), .count(count_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2);
    in_valid = 1; in_pc = pc; in_pcp4 = pc + 4; in_imm = pc ^ 32'hFFFF_0000; in_ctrl = pc[23:0] ^ 24'hA5A5A5;
    in_rs1 = r1; in_rs1_data = d1; in_rs2 = r2; in_rs2_data = d2; in_rd = pc[6:2];
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else passed++;
    total++; if (count !== 2'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passed++;
    total++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc got %h want 0", out_pc); else passed++;
  endtask

  task automatic test_enqueue();
    offer(32'h100, 5'd1, 32'h1, 5'd2, 32'h2); tick(); in_valid = 0;
    total++; if (out_valid !== 1'b1) $display("FAIL enq_valid got %0b want 1", out_valid); else passed++;
    total++; if (out_pc !== 32'h100) $display("FAIL enq_pc got %h want 100", out_pc); else passed++;
    total++; if (count !== 2'd1) $display("FAIL enq_count got %0d want 1", count); else passed++;
    total++; if (out_pcp4 !== 32'h104) $display("FAIL enq_pcp4 got %h want 104", out_pcp4); else passed++;
    total++; if (out_ctrl !== 24'hA5A4A5) $display("FAIL enq_ctrl got %h want a5a4a5", out_ctrl); else passed++;
    total++; if (out_imm !== 32'hFFFF_0100) $display("FAIL enq_imm got %h want ffff0100", out_imm); else passed++;
    total++; if (out_rd !== 5'd0 || out_rs2 !== 5'd2) $display("FAIL enq_idx got rd=%0d rs2=%0d want 0 2", out_rd, out_rs2); else passed++;
    out_ready = 1; tick(); out_ready = 0;
    total++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL deq_empty got count=%0d valid=%0b want 0 0", count, out_valid); else passed++;
    total++; if (out_pc !== 32'h0 || out_ctrl !== 24'h0) $display("FAIL empty_zero got pc=%h ctrl=%h want 0 0", out_pc, out_ctrl); else passed++;
  endtask

  task automatic test_full();
    offer(32'h100, 0, 0, 0, 0); tick();
    offer(32'h104, 0, 0, 0, 0); tick();
    total++; if (count !== 2'd2) $display("FAIL full_count got %0d want 2", count); else passed++;
    offer(32'h108, 0, 0, 0, 0); out_ready = 1;
    total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %0b want 0", in_ready); else passed++;
    total++; if (out_pc !== 32'h100) $display("FAIL full_head got %h want 100", out_pc); else passed++;
    tick(); in_valid = 0;
    total++; if (count !== 2'd1 || out_pc !== 32'h104) $display("FAIL full_second got count=%0d pc=%h want 1 104", count, out_pc); else passed++;
    tick(); out_ready = 0;
    total++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL full_rejected got count=%0d valid=%0b want 0 0", count, out_valid); else passed++;
  endtask

  task automatic test_bypass_in();
    offer(32'h120, 5'd5, 32'h11, 5'd6, 32'h22); wb_en = 1; wb_rd = 5'd5; wb_data = 32'hAA; tick();
    in_valid = 0; wb_en = 0;
    total++; if (out_rs1_data !== 32'hAA) $display("FAIL byp_in_rs1 got %h want aa", out_rs1_data); else passed++;
    total++; if (out_rs2_data !== 32'h22) $display("FAIL byp_in_rs2 got %h want 22", out_rs2_data); else passed++;
    total++; if (out_rs1_data_b !== 32'h11) $display("FAIL byp_in_off got %h want 11", out_rs1_data_b); else passed++;
    out_ready = 1; tick(); out_ready = 0;
    offer(32'h124, 5'd0, 32'h11, 5'd0, 32'h33); wb_en = 1; wb_rd = 5'd0; wb_data = 32'hAA; tick();
    in_valid = 0; wb_en = 0;
    total++; if (out_rs1_data !== 32'h11) $display("FAIL byp_in_x0_rs1 got %h want 11", out_rs1_data); else passed++;
    total++; if (out_rs2_data !== 32'h33) $display("FAIL byp_in_x0_rs2 got %h want 33", out_rs2_data); else passed++;
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_bypass_stored();
    offer(32'h140, 5'd0, 32'h44, 5'd7, 32'h33); tick(); in_valid = 0;
    tick();
    wb_en = 1; wb_rd = 5'd7; wb_data = 32'h55; tick();
    total++; if (out_rs2_data !== 32'h55) $display("FAIL byp_st_rs2 got %h want 55", out_rs2_data); else passed++;
    total++; if (out_rs2_data_b !== 32'h33) $display("FAIL byp_st_off got %h want 33", out_rs2_data_b); else passed++;
    wb_rd = 5'd0; wb_data = 32'h66; tick(); wb_en = 0;
    total++; if (out_rs1_data !== 32'h44 || out_rs2_data !== 32'h55) $display("FAIL byp_st_x0 got rs1=%h rs2=%h want 44 55", out_rs1_data, out_rs2_data); else passed++;
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_flush();
    offer(32'h180, 0, 0, 0, 0); tick();
    offer(32'h184, 0, 0, 0, 0); tick();
    offer(32'h200, 0, 0, 0, 0); flush = 1; out_ready = 1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %0b want 0", in_ready); else passed++;
    tick(); flush = 0; in_valid = 0; out_ready = 0;
    total++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL flush_empty got count=%0d valid=%0b want 0 0", count, out_valid); else passed++;
    total++; if (out_pc !== 32'h0 || out_pcp4 !== 32'h0 || out_ctrl !== 24'h0 || out_rd !== 5'd0) $display("FAIL flush_zero got pc=%h pcp4=%h ctrl=%h rd=%0d want 0", out_pc, out_pcp4, out_ctrl, out_rd); else passed++;
    tick();
    total++; if (count !== 2'd0) $display("FAIL flush_dropped got %0d want 0", count); else passed++;
  endtask

  task automatic test_wrap();
    int sent = 0, seen = 0;
    for (int c = 0; c < 40 && seen < 6; c++) begin
      out_ready = c[0];
      if (sent < 6 && in_ready) offer(32'h300 + 32'(4 * sent), 0, 0, 0, 0); else in_valid = 0;
      if (out_valid && out_ready) begin
        total++; if (out_pc !== 32'h300 + 32'(4 * seen)) $display("FAIL wrap_order got %h want %h", out_pc, 32'h300 + 32'(4 * seen)); else passed++;
        seen++;
      end
      if (in_valid) sent++;
      tick();
    end
    in_valid = 0; out_ready = 0;
    total++; if (seen !== 6) $display("FAIL wrap_seen got %0d want 6", seen); else passed++;
    total++; if (count !== 2'd0) $display("FAIL wrap_count got %0d want 0", count); else passed++;
  endtask

  initial begin
    test_reset();
    test_enqueue();
    test_full();
    test_bypass_in();
    test_bypass_stored();
    test_flush();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
